// File: rtl/lcd_scan_ctrl.sv
// lcd_scan_ctrl: powers up and initialises an HD44780-style 16x2 LCD, then refreshes both
// lines forever. For each character it broadcasts a screen index to the mode blocks, takes
// the code of the selected mode and drives RS/E/data paced by en_tick. Mode button pulses
// rotate mode_sel, applied only at frame boundaries.
module lcd_scan_ctrl #(
  parameter int unsigned NMODES      = 4,
  parameter int unsigned POWER_TICKS = 20,
  parameter int unsigned CLR_TICKS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_tick,
  input  logic       mode_btn,
  input  logic [7:0] char0,
  input  logic [7:0] char1,
  input  logic [7:0] char2,
  input  logic [7:0] char3,
  output logic [4:0] index,
  output logic [1:0] mode_sel,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_start
);

  localparam logic [15:0] PowerCnt = 16'(POWER_TICKS);
  localparam logic [15:0] ClrCnt   = 16'(CLR_TICKS);
  localparam logic [1:0]  ModeMax  = 2'(NMODES - 1);

  typedef enum logic [2:0] {StPwait, StInit, StLine1Cmd, StChars, StLine2Cmd} state_e;
  typedef enum logic [1:0] {PhFetch, PhSetup, PhPulse, PhHold} phase_e;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic [4:0]  index_q, index_d;
  logic [1:0]  mode_sel_q, mode_sel_d;
  logic        pending_q, pending_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        lcd_e_q, lcd_e_d;
  logic [7:0]  lcd_data_q, lcd_data_d;
  logic        init_done_q, init_done_d;
  logic        frame_start_q, frame_start_d;
  logic        enter_frame;
  logic [7:0]  char_sel;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Character code of the active mode
  always_comb begin
    char_sel = char0;
    case (mode_sel_q)
      2'd1:    char_sel = char1;
      2'd2:    char_sel = char2;
      2'd3:    char_sel = char3;
      default: char_sel = char0;
    endcase
  end

  // State, counters and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StPwait;
      phase_q       <= PhFetch;
      cnt_q         <= '0;
      init_idx_q    <= '0;
      index_q       <= '0;
      mode_sel_q    <= '0;
      pending_q     <= 1'b0;
      lcd_rs_q      <= 1'b0;
      lcd_e_q       <= 1'b0;
      lcd_data_q    <= '0;
      init_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      init_idx_q    <= init_idx_d;
      index_q       <= index_d;
      mode_sel_q    <= mode_sel_d;
      pending_q     <= pending_d;
      lcd_rs_q      <= lcd_rs_d;
      lcd_e_q       <= lcd_e_d;
      lcd_data_q    <= lcd_data_d;
      init_done_q   <= init_done_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Sequencer: advances only on en_tick
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    init_idx_d = init_idx_q;
    index_d    = index_q;
    if (en_tick) begin
      case (state_q)
        StPwait: begin
          if (cnt_q == PowerCnt) begin
            cnt_d      = '0;
            init_idx_d = '0;
            state_d    = StInit;
            phase_d    = PhSetup;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StInit: begin
          case (phase_q)
            PhSetup: phase_d = PhPulse;
            PhPulse: phase_d = PhHold;
            default: begin
              if (init_idx_q != 2'd3) begin
                init_idx_d = init_idx_q + 2'd1;
                phase_d    = PhSetup;
              end else if (cnt_q == ClrCnt) begin
                // Clear-display settle time is spent parked in HOLD
                cnt_d   = '0;
                state_d = StLine1Cmd;
                phase_d = PhSetup;
              end else begin
                cnt_d = cnt_q + 16'd1;
              end
            end
          endcase
        end
        StLine1Cmd, StLine2Cmd: begin
          case (phase_q)
            PhSetup: phase_d = PhPulse;
            PhPulse: phase_d = PhHold;
            default: begin
              state_d = StChars;
              phase_d = PhFetch;
              index_d = (state_q == StLine1Cmd) ? 5'd0 : 5'd16;
            end
          endcase
        end
        StChars: begin
          case (phase_q)
            PhFetch: phase_d = PhSetup;
            PhSetup: phase_d = PhPulse;
            PhPulse: phase_d = PhHold;
            default: begin
              if (index_q == 5'd15) begin
                state_d = StLine2Cmd;
                phase_d = PhSetup;
              end else if (index_q == 5'd31) begin
                state_d = StLine1Cmd;
                phase_d = PhSetup;
              end else begin
                index_d = index_q + 5'd1;
                phase_d = PhFetch;
              end
            end
          endcase
        end
        default: begin
          state_d = StPwait;
          phase_d = PhFetch;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output next-values derived from the state being entered
  always_comb begin
    lcd_rs_d   = lcd_rs_q;
    lcd_data_d = lcd_data_q;
    lcd_e_d    = (state_d != StPwait) && (phase_d == PhSetup ? 1'b0 : phase_d == PhPulse);
    // SETUP always lasts one tick, so any tick landing in SETUP is an entry
    if (en_tick && phase_d == PhSetup) begin
      case (state_d)
        StInit: begin
          lcd_rs_d   = 1'b0;
          lcd_data_d = init_cmd(init_idx_d);
        end
        StLine1Cmd: begin
          lcd_rs_d   = 1'b0;
          lcd_data_d = 8'h80;
        end
        StLine2Cmd: begin
          lcd_rs_d   = 1'b0;
          lcd_data_d = 8'hC0;
        end
        StChars: begin
          lcd_rs_d   = 1'b1;
          lcd_data_d = char_sel;
        end
        default: ;
      endcase
    end
    enter_frame   = en_tick && (state_d == StLine1Cmd) && (state_q != StLine1Cmd);
    frame_start_d = enter_frame;
    init_done_d   = init_done_q | enter_frame;
    // A pulse on the boundary clk survives for the next frame
    pending_d     = mode_btn | (pending_q & ~enter_frame);
    mode_sel_d    = mode_sel_q;
    if (enter_frame && pending_q) begin
      mode_sel_d = (mode_sel_q == ModeMax) ? 2'd0 : mode_sel_q + 2'd1;
    end
  end

  assign index       = index_q;
  assign mode_sel    = mode_sel_q;
  assign lcd_rs      = lcd_rs_q;
  assign lcd_rw      = 1'b0;
  assign lcd_e       = lcd_e_q;
  assign lcd_data    = lcd_data_q;
  assign init_done   = init_done_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_scan_ctrl.sv
// Bench for lcd_scan_ctrl: random en_tick spacing and mode button pulses, checked every clk
// against a tick-count based reference of the init sequence and the 134-tick frame.
module tb_lcd_scan_ctrl;

  localparam int P     = 2;
  localparam int C     = 2;
  localparam int NM    = 4;
  localparam int FRAME = 134;
  localparam int FIRST = P + 1 + 12 + C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_tick = 1'b0;
  logic       mode_btn = 1'b0;
  logic [7:0] char0, char1, char2, char3;
  logic [4:0] index;
  logic [1:0] mode_sel;
  logic       lcd_rs, lcd_rw, lcd_e, init_done, frame_start;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_scan_ctrl #(
    .NMODES     (NM),
    .POWER_TICKS(P),
    .CLR_TICKS  (C)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en_tick    (en_tick),
    .mode_btn   (mode_btn),
    .char0      (char0),
    .char1      (char1),
    .char2      (char2),
    .char3      (char3),
    .index      (index),
    .mode_sel   (mode_sel),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .lcd_data   (lcd_data),
    .init_done  (init_done),
    .frame_start(frame_start)
  );

  // Character a given mode shows at a given position; modes differ by 0x40
  function automatic logic [7:0] ch(input int md, input int p);
    return 8'((md * 64 + 65 + p) & 255);
  endfunction

  // Mode blocks: one clk of registered latency after index
  always @(posedge clk) begin
    char0 <= ch(0, int'(index));
    char1 <= ch(1, int'(index));
    char2 <= ch(2, int'(index));
    char3 <= ch(3, int'(index));
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int t;
  int md;
  bit pend;
  bit fs_exp;
  int gap;
  int gap_tgt;
  int stage;
  bit pwait_btn_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d, time %0t)", tag, got, exp, t, $time);
    end
  endtask

  // Expected outputs after tick t, from init schedule and frame layout
  task automatic model_out(input int tt, input int mdv, output logic e, output logic rs,
                           output logic [7:0] d, output logic [4:0] idx, output logic idone);
    int k, fo, fr, p, sub;
    e = 1'b0; rs = 1'b0; d = 8'h00; idx = 5'd0; idone = 1'b0;
    if (tt <= P) begin
      d = 8'h00;
    end else if (tt < P + 13) begin
      k   = tt - (P + 1);
      sub = k % 3;
      e   = (sub == 1);
      case (k / 3)
        0:       d = 8'h38;
        1:       d = 8'h0C;
        2:       d = 8'h06;
        default: d = 8'h01;
      endcase
    end else if (tt < FIRST) begin
      d = 8'h01;
    end else begin
      idone = 1'b1;
      fo = (tt - FIRST) % FRAME;
      fr = (tt - FIRST) / FRAME;
      if (fo < 3) begin
        d = 8'h80; e = (fo == 1); idx = (fr == 0) ? 5'd0 : 5'd31;
      end else if (fo >= 67 && fo < 70) begin
        d = 8'hC0; e = (fo == 68); idx = 5'd15;
      end else begin
        p   = (fo < 67) ? (fo - 3) / 4 : 16 + (fo - 70) / 4;
        sub = (fo < 67) ? (fo - 3) % 4 : (fo - 70) % 4;
        idx = 5'(p);
        e   = (sub == 2);
        if (sub != 0) begin
          rs = 1'b1; d = ch(mdv, p);
        end else if (p == 0) begin
          d = 8'h80;
        end else if (p == 16) begin
          d = 8'hC0;
        end else begin
          rs = 1'b1; d = ch(mdv, p - 1);
        end
      end
    end
  endtask

  task automatic check_cycle();
    logic e, rs, idone;
    logic [7:0] d;
    logic [4:0] idx;
    model_out(t, md, e, rs, d, idx, idone);
    check("lcd_e", 32'(lcd_e), 32'(e));
    check("lcd_rs", 32'(lcd_rs), 32'(rs));
    check("lcd_data", 32'(lcd_data), 32'(d));
    check("index", 32'(index), 32'(idx));
    check("init_done", 32'(init_done), 32'(idone));
    check("frame_start", 32'(frame_start), 32'(fs_exp));
    check("mode_sel", 32'(mode_sel), 32'(md));
    check("lcd_rw", 32'(lcd_rw), 32'd0);
  endtask

  // Pick inputs for the coming posedge and advance the reference across it
  task automatic drive_next();
    bit en, btn, boundary;
    int tn, fo_n, fr_n;
    gap++;
    en = (gap >= gap_tgt);
    if (en) begin
      gap     = 0;
      gap_tgt = $urandom_range(4, 6);
    end
    tn       = en ? t + 1 : t;
    fo_n     = (tn >= FIRST) ? (tn - FIRST) % FRAME : -1;
    fr_n     = (tn >= FIRST) ? (tn - FIRST) / FRAME : -1;
    boundary = en && (fo_n == 0);
    btn      = 1'b0;
    if (stage == 1 && !pwait_btn_done && t == 1) begin
      btn = 1'b1; pwait_btn_done = 1'b1;
    end
    if (stage == 0 && en) begin
      if (fr_n == 1 && fo_n == 3 + 7 * 4) btn = 1'b1;
      if (fr_n == 2 && (fo_n == 10 || fo_n == 50 || fo_n == 100)) btn = 1'b1;
      if (fr_n == 3 && fo_n == 40) btn = 1'b1;
      if (fr_n == 4 && fo_n == 0) btn = 1'b1;
    end
    if (stage == 0 && fr_n >= 5 && $urandom_range(0, 149) == 0) btn = 1'b1;
    if (boundary) begin
      if (pend) md = (md + 1) % NM;
      pend = btn;
    end else if (btn) begin
      pend = 1'b1;
    end
    fs_exp   = boundary;
    t        = tn;
    en_tick  = en;
    mode_btn = btn;
  endtask

  task automatic model_reset();
    t = 0; md = 0; pend = 1'b0; fs_exp = 1'b0; gap = 0; gap_tgt = 4;
  endtask

  task automatic check_reset_values();
    check("rst_lcd_e", 32'(lcd_e), 32'd0);
    check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    check("rst_lcd_data", 32'(lcd_data), 32'd0);
    check("rst_index", 32'(index), 32'd0);
    check("rst_mode_sel", 32'(mode_sel), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_lcd_rw", 32'(lcd_rw), 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  done;
    model_reset();
    stage = 0;
    pwait_btn_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b1;
    drive_next();
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      check_cycle();
      if (stage == 0 && t >= FIRST && (t - FIRST) / FRAME == 8 && (t - FIRST) % FRAME == 88) begin
        // Position 20 is in its PULSE tick: pull reset while lcd_e is high
        check("e_before_rst", 32'(lcd_e), 32'd1);
        en_tick  = 1'b0;
        mode_btn = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_values();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst   = 1'b1;
        stage = 1;
        model_reset();
        drive_next();
      end else if (stage == 1 && t >= FIRST + 2 * FRAME + 5) begin
        done = 1'b1;
      end else begin
        drive_next();
      end
      if (cyc > 40000) begin
        check("cycle_budget", 32'(cyc), 32'd40000);
        done = 1'b1;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
